// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: controller FSM state encoding and bus response codes.
// Used by both the master and the slave controllers.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } axi_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic resp_is_error(input logic [1:0] resp);
        logic err;
        case (resp)
            RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
            RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default:                  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// AXI-Lite master: turns single read/write commands into AXI-Lite transactions,
// with a per-state wait timeout that aborts a stalled bus access.
module axi_lite_master #(
    parameter int AXI_ADDRESS_WIDTH = 5,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [AXI_ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                  cmd_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_rdata,
    output logic                         rsp_err,
    output logic                         rsp_timeout,
    output logic [AXI_ADDRESS_WIDTH-1:0] maxi_awaddr,
    output logic                         maxi_awvalid,
    input  logic                         maxi_awready,
    output logic [31:0]                  maxi_wdata,
    output logic                         maxi_wvalid,
    input  logic                         maxi_wready,
    input  logic [1:0]                   maxi_bresp,
    input  logic                         maxi_bvalid,
    output logic                         maxi_bready,
    output logic [AXI_ADDRESS_WIDTH-1:0] maxi_araddr,
    output logic                         maxi_arvalid,
    input  logic                         maxi_arready,
    input  logic [31:0]                  maxi_rdata,
    input  logic [1:0]                   maxi_rresp,
    input  logic                         maxi_rvalid,
    output logic                         maxi_rready
);
    import axi_lite_pkg::*;

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    axi_state_t                   r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_awvalid;
    logic                         r_wvalid;
    logic                         r_arvalid;
    logic                         r_bready;
    logic                         r_rready;
    logic [AXI_ADDRESS_WIDTH-1:0] r_awaddr;
    logic [AXI_ADDRESS_WIDTH-1:0] r_araddr;
    logic [31:0]                  r_wdata;
    logic                         r_rsp_valid;
    logic                         r_rsp_err;
    logic                         r_rsp_timeout;
    logic [31:0]                  r_rsp_rdata;

    logic                         w_aw_hs;
    logic                         w_w_hs;
    logic                         w_ar_hs;
    logic                         w_b_hs;
    logic                         w_r_hs;
    logic                         w_aw_done;
    logic                         w_w_done;
    logic                         w_expired;
    logic [CNT_W-1:0]             w_cnt_next;

    assign w_aw_hs    = r_awvalid && maxi_awready;
    assign w_w_hs     = r_wvalid  && maxi_wready;
    assign w_ar_hs    = r_arvalid && maxi_arready;
    assign w_b_hs     = r_bready  && maxi_bvalid;
    assign w_r_hs     = r_rready  && maxi_rvalid;
    assign w_aw_done  = !r_awvalid || maxi_awready;
    assign w_w_done   = !r_wvalid  || maxi_wready;
    // The cycle in which the counter would reach the limit is the last one allowed.
    assign w_expired  = (r_cnt >= CNT_LAST);
    assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    assign cmd_ready    = aresetn && (r_state == IDLE);
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;
    assign rsp_timeout  = r_rsp_timeout;
    assign maxi_awaddr  = r_awaddr;
    assign maxi_awvalid = r_awvalid;
    assign maxi_wdata   = r_wdata;
    assign maxi_wvalid  = r_wvalid;
    assign maxi_bready  = r_bready;
    assign maxi_araddr  = r_araddr;
    assign maxi_arvalid = r_arvalid;
    assign maxi_rready  = r_rready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_bready      <= 1'b0;
            r_rready      <= 1'b0;
            r_awaddr      <= '0;
            r_araddr      <= '0;
            r_wdata       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR_REQ;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= RD_REQ;
                        end
                    end
                end
                // AW and W complete independently; a handshake this cycle defers the timeout.
                WR_REQ: begin
                    r_cnt <= w_cnt_next;
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_cnt    <= '0;
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end else if (w_expired && !w_aw_hs && !w_w_hs) begin
                        r_cnt         <= '0;
                        r_awvalid     <= 1'b0;
                        r_wvalid      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_state       <= DONE;
                    end
                end
                WR_RESP: begin
                    r_cnt <= w_cnt_next;
                    if (w_b_hs || w_expired) begin
                        r_cnt         <= '0;
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= w_b_hs ? resp_is_error(maxi_bresp) : 1'b1;
                        r_rsp_timeout <= !w_b_hs;
                        r_rsp_rdata   <= '0;
                        r_state       <= DONE;
                    end
                end
                RD_REQ: begin
                    r_cnt <= w_cnt_next;
                    if (w_ar_hs) begin
                        r_cnt     <= '0;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end else if (w_expired) begin
                        r_cnt         <= '0;
                        r_arvalid     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_state       <= DONE;
                    end
                end
                RD_DATA: begin
                    r_cnt <= w_cnt_next;
                    if (w_r_hs || w_expired) begin
                        r_cnt         <= '0;
                        r_rready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= w_r_hs ? resp_is_error(maxi_rresp) : 1'b1;
                        r_rsp_timeout <= !w_r_hs;
                        r_rsp_rdata   <= w_r_hs ? maxi_rdata : 32'h0;
                        r_state       <= DONE;
                    end
                end
                DONE: begin
                    r_cnt <= '0;
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a configurable AXI-Lite slave model
// (per-channel ready/valid delays, response codes, word-addressed registers).
module tb_axi_lite_master;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [4:0]  maxi_awaddr;
    logic        maxi_awvalid;
    logic        maxi_awready = 1'b0;
    logic [31:0] maxi_wdata;
    logic        maxi_wvalid;
    logic        maxi_wready = 1'b0;
    logic [1:0]  maxi_bresp = 2'b00;
    logic        maxi_bvalid = 1'b0;
    logic        maxi_bready;
    logic [4:0]  maxi_araddr;
    logic        maxi_arvalid;
    logic        maxi_arready = 1'b0;
    logic [31:0] maxi_rdata = '0;
    logic [1:0]  maxi_rresp = 2'b00;
    logic        maxi_rvalid = 1'b0;
    logic        maxi_rready;

    axi_lite_master #(.AXI_ADDRESS_WIDTH(5), .TIMEOUT_CYCLES(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .maxi_awaddr(maxi_awaddr), .maxi_awvalid(maxi_awvalid), .maxi_awready(maxi_awready),
        .maxi_wdata(maxi_wdata), .maxi_wvalid(maxi_wvalid), .maxi_wready(maxi_wready),
        .maxi_bresp(maxi_bresp), .maxi_bvalid(maxi_bvalid), .maxi_bready(maxi_bready),
        .maxi_araddr(maxi_araddr), .maxi_arvalid(maxi_arvalid), .maxi_arready(maxi_arready),
        .maxi_rdata(maxi_rdata), .maxi_rresp(maxi_rresp), .maxi_rvalid(maxi_rvalid),
        .maxi_rready(maxi_rready)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    int         awDelay = 0, wDelay = 0, bDelay = 0, arDelay = 0, rDelay = 0;
    logic [1:0] bRespCfg = 2'b00, rRespCfg = 2'b00;
    bit         spurious = 1'b0;

    logic [31:0] regs [8] = '{default: 32'h0};
    int          awWait = 0, wWait = 0, bWait = 0, arWait = 0, rWait = 0;
    bit          gotAw = 0, gotW = 0, gotAr = 0, committed = 0;
    logic [4:0]  wAddr = '0, rAddr = '0;
    logic [31:0] wData = '0;
    int          awHs = 0, wHs = 0, bHs = 0, arHs = 0, rHs = 0;
    int          readyGaps = 0, stabErrs = 0, arvCycles = 0;
    bit          pAw = 0, pW = 0, pAr = 0;
    logic [4:0]  pAwAddr = '0, pArAddr = '0;
    logic [31:0] pWData = '0;

    // Slave bookkeeping sampled on the active edge, plus protocol monitors.
    always @(posedge aclk) begin
        if (!aresetn) begin
            gotAw = 0; gotW = 0; gotAr = 0; committed = 0;
            awWait = 0; wWait = 0; bWait = 0; arWait = 0; rWait = 0;
            pAw = 0; pW = 0; pAr = 0;
        end else begin
            if (maxi_arvalid) arvCycles++;
            if (gotAr != maxi_rready) readyGaps++;
            if ((gotAw && gotW) != maxi_bready) readyGaps++;
            if (pAw && (!maxi_awvalid || maxi_awaddr != pAwAddr)) stabErrs++;
            if (pW && (!maxi_wvalid || maxi_wdata != pWData)) stabErrs++;
            if (pAr && maxi_arvalid && maxi_araddr != pArAddr) stabErrs++;
            pAw = maxi_awvalid && !maxi_awready; pAwAddr = maxi_awaddr;
            pW  = maxi_wvalid && !maxi_wready;   pWData  = maxi_wdata;
            pAr = maxi_arvalid && !maxi_arready; pArAddr = maxi_araddr;
            if (maxi_bvalid && maxi_bready && gotAw && gotW) begin
                bHs++; gotAw = 0; gotW = 0; committed = 0; bWait = 0;
            end else if (gotAw && gotW) bWait++;
            if (maxi_rvalid && maxi_rready && gotAr) begin
                rHs++; gotAr = 0; rWait = 0;
            end else if (gotAr) rWait++;
            if (maxi_awvalid && maxi_awready) begin
                awHs++; wAddr = maxi_awaddr; gotAw = 1; awWait = 0;
            end else if (maxi_awvalid) awWait++; else awWait = 0;
            if (maxi_wvalid && maxi_wready) begin
                wHs++; wData = maxi_wdata; gotW = 1; wWait = 0;
            end else if (maxi_wvalid) wWait++; else wWait = 0;
            if (maxi_arvalid && maxi_arready) begin
                arHs++; rAddr = maxi_araddr; gotAr = 1; arWait = 0;
            end else if (maxi_arvalid) arWait++; else arWait = 0;
            if (gotAw && gotW && !committed) begin
                regs[wAddr[4:2]] = wData; committed = 1;
            end
        end
    end

    always @(negedge aclk) begin
        if (!aresetn) begin
            maxi_awready = 0; maxi_wready = 0; maxi_arready = 0;
            maxi_bvalid = 0; maxi_rvalid = 0; maxi_rdata = '0;
        end else begin
            maxi_awready = maxi_awvalid && awDelay >= 0 && awWait >= awDelay;
            maxi_wready  = maxi_wvalid  && wDelay  >= 0 && wWait  >= wDelay;
            maxi_arready = maxi_arvalid && arDelay >= 0 && arWait >= arDelay;
            maxi_bvalid  = spurious || (gotAw && gotW && bWait >= bDelay);
            maxi_bresp   = bRespCfg;
            maxi_rvalid  = spurious || (gotAr && rWait >= rDelay);
            maxi_rdata   = gotAr ? regs[rAddr[4:2]] : 32'h0;
            maxi_rresp   = rRespCfg;
        end
    end

    task automatic issueCmd(input bit wr, input logic [4:0] addr, input logic [31:0] data);
        int n;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge aclk);
        cmd_valid = 0;
    endtask

    task automatic waitRsp(output logic [31:0] rd, output bit err, output bit to);
        int n;
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge aclk); n++; end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rsp_wait: rsp_valid=%b required 1 within 100 cycles", rsp_valid);
        end
        rd = rsp_rdata; err = rsp_err; to = rsp_timeout;
        rsp_ready = 1;
        @(negedge aclk);
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        checks++;
        if ({cmd_ready, maxi_awvalid, maxi_wvalid, maxi_arvalid, maxi_bready, maxi_rready,
             rsp_valid, rsp_err, rsp_timeout} !== 9'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b required 000000000", {cmd_ready, maxi_awvalid,
                maxi_wvalid, maxi_arvalid, maxi_bready, maxi_rready, rsp_valid, rsp_err, rsp_timeout});
        end
        checks++;
        if ({maxi_awaddr, maxi_araddr, maxi_wdata, rsp_rdata} !== 74'b0) begin
            failures++;
            $display("[TB] FAIL reset_data: awaddr=%h araddr=%h wdata=%h rdata=%h required 0",
                maxi_awaddr, maxi_araddr, maxi_wdata, rsp_rdata);
        end
        aresetn = 1;
        @(negedge aclk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_write_basic();
        logic [31:0] rd; bit err, to; int aw0, w0, b0;
        aw0 = awHs; w0 = wHs; b0 = bHs;
        issueCmd(1, 5'h04, 32'hDEADBEEF);
        checks++;
        if ({maxi_awvalid, maxi_wvalid, maxi_awaddr, maxi_wdata} !== {2'b11, 5'h04, 32'hDEADBEEF}) begin
            failures++;
            $display("[TB] FAIL wr_request: aw=%b w=%b addr=%h data=%h required 1 1 04 deadbeef",
                maxi_awvalid, maxi_wvalid, maxi_awaddr, maxi_wdata);
        end
        waitRsp(rd, err, to);
        checks++;
        if ({err, to, rd} !== {2'b00, 32'h0}) begin
            failures++;
            $display("[TB] FAIL wr_basic_rsp: err=%b to=%b rdata=%h required 0 0 0", err, to, rd);
        end
        checks++;
        if ({awHs - aw0, wHs - w0, bHs - b0} !== {32'd1, 32'd1, 32'd1}) begin
            failures++;
            $display("[TB] FAIL wr_basic_hs: aw=%0d w=%0d b=%0d required 1 1 1",
                awHs - aw0, wHs - w0, bHs - b0);
        end
        checks++;
        if (regs[1] !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL wr_basic_reg: reg=%h required deadbeef", regs[1]);
        end
    endtask

    task automatic test_write_w_first();
        logic [31:0] rd; bit err, to; int b0;
        b0 = bHs; awDelay = 3; wDelay = 0;
        issueCmd(1, 5'h08, 32'hA5A50001);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            checks++;
            if ({maxi_awvalid, maxi_wvalid} !== 2'b10) begin
                failures++;
                $display("[TB] FAIL wr_wfirst_valids[%0d]: aw=%b w=%b required 1 0",
                    i, maxi_awvalid, maxi_wvalid);
            end
        end
        waitRsp(rd, err, to);
        checks++;
        if ({err, to, bHs - b0} !== {2'b00, 32'd1}) begin
            failures++;
            $display("[TB] FAIL wr_wfirst_rsp: err=%b to=%b bhs=%0d required 0 0 1", err, to, bHs - b0);
        end
        checks++;
        if (regs[2] !== 32'hA5A50001) begin
            failures++;
            $display("[TB] FAIL wr_wfirst_reg: reg=%h required a5a50001", regs[2]);
        end
        awDelay = 0;
    endtask

    task automatic test_read_delay();
        logic [31:0] rd; bit err, to; int g0;
        issueCmd(1, 5'h00, 32'h12345678);
        waitRsp(rd, err, to);
        g0 = readyGaps; rDelay = 5;
        issueCmd(0, 5'h00, 32'h0);
        waitRsp(rd, err, to);
        checks++;
        if ({rd, err, to} !== {32'h12345678, 2'b00}) begin
            failures++;
            $display("[TB] FAIL rd_delay_rsp: rdata=%h err=%b to=%b required 12345678 0 0", rd, err, to);
        end
        checks++;
        if (readyGaps - g0 !== 0) begin
            failures++;
            $display("[TB] FAIL rd_ready_window: %0d cycles with ready outside its state, required 0",
                readyGaps - g0);
        end
        rDelay = 0;
    endtask

    task automatic test_error_responses();
        logic [31:0] rd; bit err, to;
        rRespCfg = 2'b10;
        issueCmd(0, 5'h08, 32'h0);
        waitRsp(rd, err, to);
        checks++;
        if ({rd, err, to} !== {32'hA5A50001, 2'b10}) begin
            failures++;
            $display("[TB] FAIL rd_slverr: rdata=%h err=%b to=%b required a5a50001 1 0", rd, err, to);
        end
        rRespCfg = 2'b01;
        issueCmd(0, 5'h08, 32'h0);
        waitRsp(rd, err, to);
        checks++;
        if ({err, to} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL rd_exokay: err=%b to=%b required 0 0", err, to);
        end
        rRespCfg = 2'b11;
        issueCmd(0, 5'h04, 32'h0);
        waitRsp(rd, err, to);
        checks++;
        if ({err, to} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL rd_decerr: err=%b to=%b required 1 0", err, to);
        end
        rRespCfg = 2'b00; bRespCfg = 2'b11;
        issueCmd(1, 5'h0C, 32'h00000001);
        waitRsp(rd, err, to);
        checks++;
        if ({rd, err, to} !== {32'h0, 2'b10}) begin
            failures++;
            $display("[TB] FAIL wr_decerr: rdata=%h err=%b to=%b required 0 1 0", rd, err, to);
        end
        bRespCfg = 2'b00;
    endtask

    task automatic test_timeout();
        logic [31:0] rd; bit err, to; int a0;
        a0 = arvCycles; arDelay = -1;
        issueCmd(0, 5'h10, 32'h0);
        waitRsp(rd, err, to);
        checks++;
        if (arvCycles - a0 !== 16) begin
            failures++;
            $display("[TB] FAIL to_arvalid_cycles: got %0d required 16", arvCycles - a0);
        end
        checks++;
        if ({rd, err, to, maxi_arvalid} !== {32'h0, 3'b110}) begin
            failures++;
            $display("[TB] FAIL to_rsp: rdata=%h err=%b to=%b arvalid=%b required 0 1 1 0",
                rd, err, to, maxi_arvalid);
        end
        arDelay = 0;
        issueCmd(0, 5'h00, 32'h0);
        waitRsp(rd, err, to);
        checks++;
        if ({rd, err, to} !== {32'h12345678, 2'b00}) begin
            failures++;
            $display("[TB] FAIL to_next_cmd: rdata=%h err=%b to=%b required 12345678 0 0", rd, err, to);
        end
    endtask

    task automatic test_ignore_spurious();
        spurious = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            checks++;
            if ({cmd_ready, rsp_valid} !== 2'b10) begin
                failures++;
                $display("[TB] FAIL spurious_idle[%0d]: cmd_ready=%b rsp_valid=%b required 1 0",
                    i, cmd_ready, rsp_valid);
            end
        end
        spurious = 0;
        @(negedge aclk);
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd; bit err, to; int n;
        bDelay = 20;
        issueCmd(1, 5'h14, 32'h00000055);
        n = 0;
        while (!maxi_bready && n < 20) begin @(negedge aclk); n++; end
        checks++;
        if (maxi_bready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_wr_resp: bready=%b required 1", maxi_bready);
        end
        aresetn = 0;
        #1;
        checks++;
        if ({cmd_ready, maxi_awvalid, maxi_wvalid, maxi_arvalid, maxi_bready, maxi_rready,
             rsp_valid, rsp_err, rsp_timeout, maxi_awaddr, maxi_araddr, maxi_wdata, rsp_rdata} !== 83'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_outputs: bready=%b awaddr=%h wdata=%h required all 0",
                maxi_bready, maxi_awaddr, maxi_wdata);
        end
        @(negedge aclk); @(negedge aclk);
        aresetn = 1; bDelay = 0;
        @(negedge aclk);
        issueCmd(1, 5'h18, 32'h00000077);
        waitRsp(rd, err, to);
        checks++;
        if ({err, to, regs[6]} !== {2'b00, 32'h00000077}) begin
            failures++;
            $display("[TB] FAIL post_reset_write: err=%b to=%b reg=%h required 0 0 77", err, to, regs[6]);
        end
        issueCmd(0, 5'h00, 32'h0);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge aclk); n++; end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h12345678}) begin
                failures++;
                $display("[TB] FAIL done_hold[%0d]: valid=%b err=%b to=%b rdata=%h required 1 0 0 12345678",
                    i, rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
            end
            @(negedge aclk);
        end
        rsp_ready = 1;
        @(negedge aclk);
        rsp_ready = 0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL done_release: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_stability();
        checks++;
        if (stabErrs !== 0) begin
            failures++;
            $display("[TB] FAIL valid_stability: %0d violations required 0", stabErrs);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_w_first();
        test_read_delay();
        test_error_responses();
        test_timeout();
        test_ignore_spurious();
        test_reset_midflight();
        test_stability();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
